paddle_input: RTL and testbench

PADDLE_INPUT -- requirements
Module: paddle_input

---
 rtl/paddle_input.sv | 187 ++++++++++++++++++
 tb/tb_paddle_input.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/paddle_input.sv
// Paddle pushbutton front end: synchronize, debounce, resolve direction, emit move commands.
// Define PADDLE_INPUT_REPEAT_EN for one-cycle strobes with auto-repeat; otherwise outputs follow the held level.
module paddle_input #(
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned REPEAT_DELAY = 32,
    parameter int unsigned REPEAT_RATE  = 4
) (
    input  logic button_clk,
    input  logic rst_n,
    input  logic key_left_n,
    input  logic key_right_n,
    output logic move_left_n,
    output logic move_right_n,
    output logic active
);

    if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 65535) begin : g_bad_debounce
        $error("paddle_input: DEBOUNCE_CNT out of range");
    end
    if (REPEAT_DELAY < 2 || REPEAT_DELAY > 65535) begin : g_bad_delay
        $error("paddle_input: REPEAT_DELAY out of range");
    end
    if (REPEAT_RATE < 2 || REPEAT_RATE > 65535) begin : g_bad_rate
        $error("paddle_input: REPEAT_RATE out of range");
    end

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CNT - 1);

    // Index 0 is the left key, index 1 the right key; all levels active-low.
    logic [1:0]  keys;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  deb;
    logic [15:0] deb_cnt [2];
    dir_t        dir;
    logic        left_nxt;
    logic        right_nxt;
    logic        active_nxt;

    assign keys = {key_right_n, key_left_n};

    always_ff @(posedge button_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge button_clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= 2'b11;
            for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DB_LAST) begin
                    deb[k]     <= sync2[k];
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] != 16'hFFFF) begin
                    deb_cnt[k] <= deb_cnt[k] + 16'd1;
                end
            end
        end
    end

    // Both keys pressed cancels out to no direction.
    always_comb begin
        dir = DIR_NONE;
        if (!deb[0] && deb[1]) begin
            dir = DIR_LEFT;
        end else if (deb[0] && !deb[1]) begin
            dir = DIR_RIGHT;
        end
    end

`ifdef PADDLE_INPUT_REPEAT_EN
    // state   | meaning
    // S_IDLE  | no direction held
    // S_FIRE  | one-cycle move strobe for cur_dir
    // S_DELAY | waiting REPEAT_DELAY after the first strobe
    // S_RATE  | waiting REPEAT_RATE between later strobes
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRE  = 2'd1,
        S_DELAY = 2'd2,
        S_RATE  = 2'd3
    } state_t;

    localparam logic [15:0] DLY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RATE_LAST = 16'(REPEAT_RATE - 1);

    state_t      state;
    state_t      state_nxt;
    dir_t        cur_dir;
    dir_t        cur_dir_nxt;
    logic        first;
    logic        first_nxt;
    logic [15:0] ivl_cnt;
    logic [15:0] ivl_cnt_nxt;

    always_ff @(posedge button_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cur_dir <= DIR_NONE;
            first   <= 1'b1;
            ivl_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cur_dir <= cur_dir_nxt;
            first   <= first_nxt;
            ivl_cnt <= ivl_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cur_dir_nxt = cur_dir;
        first_nxt   = first;
        ivl_cnt_nxt = ivl_cnt;
        case (state)
            S_IDLE: begin
                if (dir != DIR_NONE) begin
                    state_nxt   = S_FIRE;
                    cur_dir_nxt = dir;
                    first_nxt   = 1'b1;
                end
            end
            S_FIRE: begin
                state_nxt   = first ? S_DELAY : S_RATE;
                ivl_cnt_nxt = '0;
            end
            S_DELAY, S_RATE: begin
                // A new direction wins over an interval expiring on the same edge.
                if (dir == DIR_NONE) begin
                    state_nxt   = S_IDLE;
                    ivl_cnt_nxt = '0;
                end else if (dir != cur_dir) begin
                    state_nxt   = S_FIRE;
                    cur_dir_nxt = dir;
                    first_nxt   = 1'b1;
                end else if (ivl_cnt == ((state == S_DELAY) ? DLY_LAST : RATE_LAST)) begin
                    state_nxt = S_FIRE;
                    first_nxt = 1'b0;
                end else if (ivl_cnt != 16'hFFFF) begin
                    ivl_cnt_nxt = ivl_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        left_nxt   = !(state_nxt == S_FIRE && cur_dir_nxt == DIR_LEFT);
        right_nxt  = !(state_nxt == S_FIRE && cur_dir_nxt == DIR_RIGHT);
        active_nxt = (state_nxt != S_IDLE);
    end
`else
    always_comb begin
        left_nxt   = (dir != DIR_LEFT);
        right_nxt  = (dir != DIR_RIGHT);
        active_nxt = (dir != DIR_NONE);
    end
`endif

    always_ff @(posedge button_clk or negedge rst_n) begin
        if (!rst_n) begin
            move_left_n  <= 1'b1;
            move_right_n <= 1'b1;
            active       <= 1'b0;
        end else begin
            move_left_n  <= left_nxt;
            move_right_n <= right_nxt;
            active       <= active_nxt;
        end
    end

endmodule

// File: tb/tb_paddle_input.sv
// Scoreboard bench for paddle_input: stimulus queues expected output changes, a monitor pops and compares.
// Expectations follow PADDLE_INPUT_REPEAT_EN the same way the design does.
module tb_paddle_input;

    logic button_clk;
    logic rst_n;
    logic key_left_n;
    logic key_right_n;
    logic move_left_n;
    logic move_right_n;
    logic active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } ev_t;

    ev_t exp_q[$];
    logic [2:0] prev_obs = 3'b110;

    paddle_input #(
        .DEBOUNCE_CNT(4),
        .REPEAT_DELAY(32),
        .REPEAT_RATE (4)
    ) dut (
        .button_clk  (button_clk),
        .rst_n       (rst_n),
        .key_left_n  (key_left_n),
        .key_right_n (key_right_n),
        .move_left_n (move_left_n),
        .move_right_n(move_right_n),
        .active      (active)
    );

    initial begin
        button_clk = 1'b0;
        forever #5 button_clk = ~button_clk;
    end

    always @(posedge button_clk) cyc <= cyc + 1;

    // Observed vector is {move_left_n, move_right_n, active}; every change must match the queue head.
    always @(negedge button_clk) begin
        logic [2:0] obs;
        ev_t        e;
        obs = {move_left_n, move_right_n, active};
        if (!move_left_n || !move_right_n) begin
            checks++;
            if (!move_left_n && !move_right_n) begin
                errors++;
                $display("FAIL excl cyc=%0d both move outputs low", cyc);
            end
        end
        if (obs !== prev_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event cyc=%0d got %b, required no change from %b", cyc, obs, prev_obs);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val !== obs) begin
                    errors++;
                    $display("FAIL event got %b at cyc %0d, required %b at cyc %0d", obs, cyc, e.val, e.cyc);
                end
            end
            prev_obs = obs;
        end
    end

    task automatic push(input int c, input logic [2:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge button_clk);
    endtask

    task automatic check_out(input string name, input logic [2:0] req);
        checks++;
        if ({move_left_n, move_right_n, active} !== req) begin
            errors++;
            $display("FAIL %s got %b required %b", name, {move_left_n, move_right_n, active}, req);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d unseen events, required 0 (next at cyc %0d)", name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        int base;
        int r;

        rst_n       = 1'b1;
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge button_clk);
        check_out("reset_state", 3'b110);
        rst_n = 1'b1;
        repeat (5) @(negedge button_clk);

        // Left held, released mid-interval.
        @(negedge button_clk);
        base = cyc;
`ifdef PADDLE_INPUT_REPEAT_EN
        push(base + 7,  3'b011); push(base + 8,  3'b111);
        push(base + 39, 3'b011); push(base + 40, 3'b111);
        push(base + 43, 3'b011); push(base + 44, 3'b111);
        push(base + 47, 3'b011); push(base + 48, 3'b111);
        push(base + 51, 3'b011); push(base + 52, 3'b111);
        push(base + 54, 3'b110);
`else
        push(base + 7,  3'b011);
        push(base + 54, 3'b110);
`endif
        key_left_n = 1'b0;
        wait_until(base + 47);
        key_left_n = 1'b1;
        wait_until(base + 70);
        check_drained("left_hold");

        // Right key bounce shorter than the debounce window.
        for (int i = 0; i < 10; i++) begin
            key_right_n = 1'b0;
            repeat (3) @(negedge button_clk);
            key_right_n = 1'b1;
            repeat (3) @(negedge button_clk);
        end
        repeat (10) @(negedge button_clk);
        check_out("glitch_idle", 3'b110);
        check_drained("glitch");

        // Both held, then right released; later swap to right on a left expiry edge.
        @(negedge button_clk);
        base = cyc;
        r    = base + 20;
`ifdef PADDLE_INPUT_REPEAT_EN
        push(r + 7,  3'b011); push(r + 8,  3'b111);
        push(r + 39, 3'b011); push(r + 40, 3'b111);
        push(r + 43, 3'b011); push(r + 44, 3'b111);
        push(r + 47, 3'b101); push(r + 48, 3'b111);
        push(r + 79, 3'b101); push(r + 80, 3'b111);
        push(r + 81, 3'b110);
`else
        push(r + 7,  3'b011);
        push(r + 47, 3'b101);
        push(r + 81, 3'b110);
`endif
        key_left_n  = 1'b0;
        key_right_n = 1'b0;
        wait_until(base + 19);
        check_out("both_held", 3'b110);
        wait_until(r);
        key_right_n = 1'b1;
        wait_until(r + 40);
        key_left_n  = 1'b0 ^ 1'b1;
        key_right_n = 1'b0;
        wait_until(r + 74);
        key_right_n = 1'b1;
        wait_until(r + 100);
        check_drained("swap");

        // Reset during the first strobe aborts it; held key restarts full latency.
        @(negedge button_clk);
        base = cyc;
        push(base + 7,  3'b011);
        push(base + 8,  3'b110);
`ifdef PADDLE_INPUT_REPEAT_EN
        push(base + 17, 3'b011); push(base + 18, 3'b111);
`else
        push(base + 17, 3'b011);
`endif
        push(base + 27, 3'b110);
        key_left_n = 1'b0;
        wait_until(base + 7);
        #2 rst_n = 1'b0;
        #1 check_out("reset_abort", 3'b110);
        wait_until(base + 10);
        rst_n = 1'b1;
        wait_until(base + 20);
        key_left_n = 1'b1;
        wait_until(base + 40);
        check_out("final_idle", 3'b110);
        check_drained("reset_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
